result_transmitter: RTL
=======================

Name: result_transmitter

Overview:
- Transmit-side counterpart to the main controller's receive phase.
- Once the controller reports the finish status, this block reads the downsampled image from result memory, one byte per address.
- It streams the bytes out over a valid/ready byte interface to the host link, then reports completion.
- It sits between the result memory read port and the outbound link, and is gated by the controller's 2-bit status.

Parameters:
ADDR_W, 14, result memory address width
DATA_W, 8, pixel/byte width
IMG_LEN, 16384, number of bytes to send (1..2^ADDR_W)
CNT_W, ADDR_W+1, width of byte_count

Ports:
clock  in  1  system clock, rising edge
reset  in  1  synchronous, active-high reset
status  in  2  controller status: 00 receive, 01 process, 10 finish, 11 treated as not-finish
mem_rd_en  out  1  result memory read strobe
mem_addr  out  ADDR_W  result memory read address
mem_rdata  in  DATA_W  read data, valid one cycle after mem_rd_en
tx_data  out  DATA_W  outbound byte
tx_valid  out  1  tx_data valid
tx_ready  in  1  sink accepts byte when tx_valid && tx_ready at rising edge
tx_busy  out  1  high in FETCH/WAIT/SEND
tx_done  out  1  high in DONE
byte_count  out  CNT_W  bytes accepted by sink in current transfer

Behaviour:
- All state and outputs are registered or decoded from the state register. No combinational path from tx_ready to any output.
- Reset (synchronous, wins over everything):
  - state=IDLE, idx=0, byte_count=0.
  - mem_rd_en=0, mem_addr=0, tx_valid=0, tx_data=0, tx_busy=0, tx_done=0.
- States: IDLE, FETCH, WAIT, SEND, DONE.
- IDLE:
  - If status==10 at the edge, go to FETCH. idx=0, byte_count=0.
  - Otherwise stay in IDLE.
- FETCH: mem_rd_en=1, mem_addr=idx. Next state is WAIT unconditionally.
- WAIT: capture tx_data<=mem_rdata at the edge, then go to SEND.
- SEND:
  - tx_valid=1; tx_data is held stable until accepted.
  - On handshake: byte_count+1. If idx==IMG_LEN-1, go to DONE; else idx+1 and go to FETCH.
  - Without handshake: stay in SEND, holding tx_valid and tx_data.
- DONE:
  - tx_done=1; byte_count holds IMG_LEN.
  - Leave for IDLE when status!=10. While status stays 10, there is no retransmit.
- Abort: in FETCH/WAIT/SEND, status!=10 at an edge sends the block to IDLE.
  - tx_valid is 0 from the next cycle.
  - byte_count keeps its partial value until the next start.
  - A handshake on the same edge still counts; abort takes precedence over the DONE transition.
- Latency:
  - First tx_valid appears 3 cycles after the edge at which IDLE samples status==10 (FETCH, WAIT, SEND).
  - With tx_ready held high, steady-state throughput is one byte per 3 cycles.
- Width rules:
  - idx is ADDR_W bits and never wraps, because the terminal compare occurs at IMG_LEN-1.
  - byte_count is CNT_W bits, so IMG_LEN=2^ADDR_W is representable.
- IMG_LEN=1: FETCH, WAIT, SEND, then DONE after a single handshake.

Decomposition:
- Shared package ds_pkg holds:
  - Status codes STAT_RECEIVE=2'b00, STAT_PROCESS=2'b01, STAT_FINISH=2'b10 (also used by the main controller).
  - Transmitter state encoding constants TX_IDLE..TX_DONE.
- No sub-module. This is a single FSM with an address counter and a byte holding register.

Test Plan:
- Reset then status=10 with IMG_LEN=4, memory {0x11,0x22,0x33,0x44}, tx_ready=1 -> bytes 11,22,33,44 in order; first tx_valid 3 cycles after status sampled; tx_done=1 and byte_count=4 after the 4th handshake.
- Same setup, tx_ready low for 5 cycles during byte 2 -> tx_valid stays 1, tx_data stays 0x22, no address advance, no duplicate or lost byte.
- status 10->00 while in SEND of byte 3 -> tx_valid=0 next cycle, state IDLE, byte_count=2; status back to 10 -> transfer restarts at address 0.
- Stay in DONE with status held at 10 for 20 cycles -> no mem_rd_en, no tx_valid; status 00 -> IDLE, tx_done=0.
- reset asserted mid-WAIT -> next cycle all outputs at reset values; status=01 or 11 -> block remains in IDLE.
- IMG_LEN=1 and random tx_ready -> exactly one byte sent, then DONE with byte_count=1.

Source files
------------

// File: rtl/ds_pkg.sv
// Shared definitions for the downsampler controller and the result transmitter:
// controller status codes and the transmitter state encoding.
package ds_pkg;

  localparam logic [1:0] STAT_RECEIVE = 2'b00;
  localparam logic [1:0] STAT_PROCESS = 2'b01;
  localparam logic [1:0] STAT_FINISH  = 2'b10;

  typedef enum logic [2:0] {
    TX_IDLE  = 3'd0,
    TX_FETCH = 3'd1,
    TX_WAIT  = 3'd2,
    TX_SEND  = 3'd3,
    TX_DONE  = 3'd4
  } tx_state_t;

endpackage

// File: rtl/result_transmitter.sv
// Reads the downsampled image out of result memory one byte per address and
// streams it to the host link over a valid/ready byte interface.
//
// state    | meaning
// ---------+------------------------------------------------------------
// TX_IDLE  | waiting for the controller to report finish
// TX_FETCH | read strobe issued for address idx
// TX_WAIT  | memory data arrives, captured into the holding register
// TX_SEND  | byte offered on tx_data/tx_valid until the sink takes it
// TX_DONE  | whole image sent; parked until status leaves finish
module result_transmitter
  import ds_pkg::*;
#(
  parameter int ADDR_W  = 14,
  parameter int DATA_W  = 8,
  parameter int IMG_LEN = 16384,
  parameter int CNT_W   = ADDR_W + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [1:0]        status,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              tx_busy,
  output logic              tx_done,
  output logic [CNT_W-1:0]  byte_count
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(IMG_LEN - 1);

  tx_state_t         state_q;
  tx_state_t         state_d;
  logic [ADDR_W-1:0] idx_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] data_q;
  logic              finish;
  logic              handshake;
  logic              last_byte;

  assign finish    = (status == STAT_FINISH);
  assign handshake = (state_q == TX_SEND) && tx_ready;
  assign last_byte = (idx_q == LAST_IDX);

  // Any non-finish status aborts an in-flight transfer, even on a handshake edge.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      TX_IDLE:  if (finish) state_d = TX_FETCH;
      TX_FETCH: state_d = finish ? TX_WAIT : TX_IDLE;
      TX_WAIT:  state_d = finish ? TX_SEND : TX_IDLE;
      TX_SEND: begin
        if (!finish)        state_d = TX_IDLE;
        else if (handshake) state_d = last_byte ? TX_DONE : TX_FETCH;
      end
      TX_DONE:  if (!finish) state_d = TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= TX_IDLE;
      idx_q   <= '0;
      count_q <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == TX_IDLE && finish) begin
        idx_q   <= '0;
        count_q <= '0;
      end
      if (state_q == TX_WAIT) data_q <= mem_rdata;
      if (handshake) begin
        count_q <= count_q + CNT_W'(1);
        if (!last_byte) idx_q <= idx_q + ADDR_W'(1);
      end
    end
  end

  assign mem_rd_en  = (state_q == TX_FETCH);
  assign mem_addr   = idx_q;
  assign tx_data    = data_q;
  assign tx_valid   = (state_q == TX_SEND);
  assign tx_busy    = (state_q == TX_FETCH) || (state_q == TX_WAIT) || (state_q == TX_SEND);
  assign tx_done    = (state_q == TX_DONE);
  assign byte_count = count_q;

endmodule
